// File: rtl/seq_alu_pkg.sv
// Shared types and helpers for the sequential ALU: opcode map, FSM states
// and the width of the MOD iteration counter.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_SLT = 3'b100,
    OP_ADD = 3'b101,
    OP_SUB = 3'b110,
    OP_MOD = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mod_unit.sv
// Restoring-remainder engine for unsigned A mod B, one quotient bit per step.
// The remainder output is the value after the current step, so the top can
// capture the final remainder on the same edge that performs the last step.
module seq_mod_unit
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_next;

  // The partial remainder is always < divisor, so the difference fits in WIDTH bits.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_diff     = w_shift[WIDTH-1:0] - r_div;
  assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];

  assign remainder  = w_rem_next;
  assign last       = (r_cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_dvd <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_dvd <= dividend;
      r_div <= divisor;
      r_cnt <= CW'(WIDTH);
    end else if (step) begin
      r_rem <= w_rem_next;
      r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_rem <= r_rem;
      r_dvd <= r_dvd;
      r_div <= r_div;
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered 8-op ALU with a multi-cycle unsigned MOD and start/busy/done
// handshake. Define SEQ_ALU_OVERFLOW_EN to add the signed-overflow output.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_bit,
  output logic             busy,
  output logic             done
`ifdef SEQ_ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  state_e           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_done;

  op_e              w_op;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_mod_load;
  logic             w_mod_step;
  logic [WIDTH-1:0] w_rem;
  logic             w_last;

  assign w_op  = op_e'(alu_ctr);
  assign w_sum = alu_src1 + alu_src2;
  assign w_dif = alu_src1 - alu_src2;

  assign w_mod_load = (r_state == IDLE) && start && (w_op == OP_MOD)
                      && (alu_src2 != {WIDTH{1'b0}});
  assign w_mod_step = (r_state == RUN);

  // Single-cycle result mux; MOD here covers only the divide-by-zero case.
  always_comb begin
    w_res = '0;
    case (w_op)
      OP_AND:  w_res = alu_src1 & alu_src2;
      OP_OR:   w_res = alu_src1 | alu_src2;
      OP_XOR:  w_res = alu_src1 ^ alu_src2;
      OP_NOR:  w_res = ~(alu_src1 | alu_src2);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_dif;
      OP_MOD:  w_res = alu_src1;
      default: w_res = '0;
    endcase
  end

`ifdef SEQ_ALU_OVERFLOW_EN
  logic w_ovf;
  logic r_ovf;

  // Signed overflow for ADD/SUB only; every other op reports 0.
  always_comb begin
    w_ovf = 1'b0;
    case (w_op)
      OP_ADD:  w_ovf = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1])
                       && (w_sum[WIDTH-1] != alu_src1[WIDTH-1]);
      OP_SUB:  w_ovf = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1])
                       && (w_dif[WIDTH-1] != alu_src1[WIDTH-1]);
      default: w_ovf = 1'b0;
    endcase
  end

  assign overflow = r_ovf;
`endif

  seq_mod_unit #(.WIDTH(WIDTH)) u_mod (
    .clk       (clk),
    .reset     (reset),
    .load      (w_mod_load),
    .step      (w_mod_step),
    .dividend  (alu_src1),
    .divisor   (alu_src2),
    .remainder (w_rem),
    .last      (w_last)
  );

  // Control FSM and output registers; outputs only move on a done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && w_mod_load) begin
            r_state <= RUN;
          end else if (start) begin
            r_result <= w_res;
            r_zero   <= (w_res == {WIDTH{1'b0}});
            r_done   <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
            r_ovf    <= w_ovf;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (w_last) begin
            r_state  <= IDLE;
            r_result <= w_rem;
            r_zero   <= (w_rem == {WIDTH{1'b0}});
            r_done   <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
            r_ovf    <= 1'b0;
`endif
          end else begin
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_result = r_result;
  assign zero_bit   = r_zero;
  assign done       = r_done;
  assign busy       = (r_state == RUN);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes expected results, a monitor
// pops and compares on every done pulse (result, zero flag, arrival cycle).
module tb_seq_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    alu_ctr;
  logic [W-1:0]  alu_src1;
  logic [W-1:0]  alu_src2;
  logic [W-1:0]  alu_result;
  logic          zero_bit;
  logic          busy;
  logic          done;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic          overflow;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         zb;
    logic         ovf;
    int           cyc;
    string        name;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_ctr    (alu_ctr),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result),
    .zero_bit   (zero_bit),
    .busy       (busy),
    .done       (done)
`ifdef SEQ_ALU_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Called right after a falling edge; the next rising edge samples start.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input logic exp_ovf, input int lat,
                       input string nm);
    exp_t e;
    start    = 1'b1;
    alu_ctr  = op;
    alu_src1 = a;
    alu_src2 = b;
    e.res  = exp_res;
    e.zb   = (exp_res == '0);
    e.ovf  = exp_ovf;
    e.cyc  = cyc + lat;
    e.name = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (q.size() == 0) begin
        n_check++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%08h at cycle %0d, want no done", alu_result, cyc);
      end else begin
        e = q.pop_front();
        check({e.name, "_result"}, alu_result, e.res);
        check({e.name, "_zero"}, {31'd0, zero_bit}, {31'd0, e.zb});
        check({e.name, "_cycle"}, W'(cyc), W'(e.cyc));
`ifdef SEQ_ALU_OVERFLOW_EN
        check({e.name, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    alu_ctr  = 3'b000;
    alu_src1 = 32'h0;
    alu_src2 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_result", alu_result, 32'h0);
    check("rst_zero", {31'd0, zero_bit}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    @(negedge clk); issue(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1, "and");
    @(negedge clk); issue(3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1, "or");
    @(negedge clk); issue(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1, "xor");
    @(negedge clk); issue(3'b011, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000, 1'b0, 1, "nor");
    @(negedge clk); issue(3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0000_0001, 1'b0, 1, "slt");
    @(negedge clk); issue(3'b101, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00E1_1233, 1'b0, 1, "add");
    @(negedge clk); issue(3'b110, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hE0FF_1235, 1'b0, 1, "sub");
    @(negedge clk); start = 1'b0;

    @(negedge clk); issue(3'b111, 32'd100, 32'd7, 32'd2, 1'b0, W + 1, "mod100_7");
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("mod_busy", {31'd0, busy}, 32'd1);
      start    = (i == 3 || i == 10 || i == W - 1);
      alu_ctr  = 3'b101;
      alu_src1 = 32'd9;
      alu_src2 = 32'd9;
    end
    @(negedge clk);
    check("mod_busy_fall", {31'd0, busy}, 32'd0);
    issue(3'b111, 32'h0000_1234, 32'h0, 32'h0000_1234, 1'b0, 1, "mod_by_zero");
    @(negedge clk); issue(3'b110, 32'd5, 32'd5, 32'h0, 1'b0, 1, "sub_zero");

    @(negedge clk); issue(3'b101, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1, "add_ovf");
    @(negedge clk); issue(3'b000, 32'h7FFF_FFFF, 32'h1, 32'h0000_0001, 1'b0, 1, "and_no_ovf");
    @(negedge clk); issue(3'b110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1, "sub_ovf");
    @(negedge clk); start = 1'b0;

    @(negedge clk);
    start    = 1'b1;
    alu_ctr  = 3'b111;
    alu_src1 = 32'd1000;
    alu_src2 = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_result", alu_result, 32'h0);
    check("abort_zero", {31'd0, zero_bit}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
`ifdef SEQ_ALU_OVERFLOW_EN
    check("abort_ovf", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;
    repeat (W + 5) @(negedge clk);
    issue(3'b101, 32'd1, 32'd1, 32'd2, 1'b0, 1, "add_after_abort");
    @(negedge clk); start = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_drained", W'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
